// File: rtl/text_cursor_writer.sv
// Character-cell cursor writer: turns decoded key codes into screen-memory writes
// and runs a full-screen blanking sweep on request.
module text_cursor_writer #(
   parameter int COLS       = 40,
   parameter int ROWS       = 15,
   parameter int CODE_W     = 10,
   parameter int PRINT_MAX  = 74,
   parameter int BREAK_CODE = 'h0F0,
   parameter int ENTER_CODE = 'h0C0,
   parameter int BKSP_CODE  = 'h108,
   parameter int BLANK      = 0,
   parameter int WRAP_MODE  = 0,
   localparam int AW        = $clog2(COLS*ROWS),
   localparam int CW        = $clog2(COLS),
   localparam int RW        = $clog2(ROWS)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              key_valid,
   input  logic [CODE_W-1:0] key_code,
   input  logic              clear_req,
   output logic              wr_en,
   output logic [AW-1:0]     wr_addr,
   output logic [CODE_W-1:0] wr_data,
   output logic [CW-1:0]     cur_col,
   output logic [RW-1:0]     cur_row,
   output logic              busy,
   output logic              clear_done,
   output logic              key_drop
);

   // state | meaning
   // IDLE  | keys are captured one cycle, then executed against the cursor
   // CLEAR | BLANK sweep over every cell, keys are dropped
   typedef enum logic {IDLE, CLEAR} state_t;

   localparam logic [CW-1:0]     LAST_COL  = CW'(COLS-1);
   localparam logic [RW-1:0]     LAST_ROW  = RW'(ROWS-1);
   localparam logic [AW-1:0]     LAST_ADDR = AW'(COLS*ROWS-1);
   localparam logic [CODE_W-1:0] K_BREAK   = CODE_W'(BREAK_CODE);
   localparam logic [CODE_W-1:0] K_ENTER   = CODE_W'(ENTER_CODE);
   localparam logic [CODE_W-1:0] K_BKSP    = CODE_W'(BKSP_CODE);
   localparam logic [CODE_W-1:0] K_PRINT   = CODE_W'(PRINT_MAX);
   localparam logic [CODE_W-1:0] K_BLANK   = CODE_W'(BLANK);

   state_t              state, state_nxt;
   logic                ignore_q, ignore_nxt;
   logic                pend_q, pend_nxt;
   logic [CODE_W-1:0]   pcode_q, pcode_nxt;
   logic [CW-1:0]       col_nxt, adv_col, ret_col;
   logic [RW-1:0]       row_nxt, adv_row, ret_row, row_down;
   logic [AW-1:0]       addr_nxt, cur_addr, ret_addr;
   logic [CODE_W-1:0]   data_nxt;
   logic                wr_en_nxt, busy_nxt, done_nxt, drop_nxt;

   always_comb begin
      row_down = (cur_row == LAST_ROW) ? ((WRAP_MODE != 0) ? LAST_ROW : '0)
                                       : cur_row + RW'(1);
      adv_col  = cur_col + CW'(1);
      adv_row  = cur_row;
      if (cur_col == LAST_COL) begin
         adv_col = '0;
         adv_row = row_down;
      end
      ret_col = cur_col - CW'(1);
      ret_row = cur_row;
      if (cur_col == '0) begin
         ret_col = LAST_COL;
         if (cur_row != '0)
            ret_row = cur_row - RW'(1);
         else if (WRAP_MODE != 0)
            ret_col = '0;   // pinned at home, BLANK still lands on address 0
         else
            ret_row = LAST_ROW;
      end
      cur_addr = AW'(cur_row) * AW'(COLS) + AW'(cur_col);
      ret_addr = AW'(ret_row) * AW'(COLS) + AW'(ret_col);
   end

   always_comb begin
      state_nxt  = state;
      col_nxt    = cur_col;
      row_nxt    = cur_row;
      ignore_nxt = ignore_q;
      pend_nxt   = 1'b0;
      pcode_nxt  = pcode_q;
      wr_en_nxt  = 1'b0;
      addr_nxt   = wr_addr;
      data_nxt   = wr_data;
      busy_nxt   = busy;
      done_nxt   = 1'b0;
      drop_nxt   = 1'b0;
      case (state)
         IDLE: begin
            if (clear_req) begin
               // a key captured last cycle is discarded along with any new one
               state_nxt = CLEAR;
               busy_nxt  = 1'b1;
               wr_en_nxt = 1'b1;
               addr_nxt  = '0;
               data_nxt  = K_BLANK;
               drop_nxt  = key_valid | pend_q;
            end else begin
               pend_nxt  = key_valid;
               pcode_nxt = key_valid ? key_code : pcode_q;
               if (pend_q) begin
                  if (ignore_q) begin
                     ignore_nxt = 1'b0;
                  end else if (pcode_q == K_BREAK) begin
                     ignore_nxt = 1'b1;
                  end else if (pcode_q < K_PRINT) begin
                     wr_en_nxt = 1'b1;
                     addr_nxt  = cur_addr;
                     data_nxt  = pcode_q;
                     col_nxt   = adv_col;
                     row_nxt   = adv_row;
                  end else if (pcode_q == K_ENTER) begin
                     col_nxt = '0;
                     row_nxt = row_down;
                  end else if (pcode_q == K_BKSP) begin
                     wr_en_nxt = 1'b1;
                     addr_nxt  = ret_addr;
                     data_nxt  = K_BLANK;
                     col_nxt   = ret_col;
                     row_nxt   = ret_row;
                  end
               end
            end
         end
         CLEAR: begin
            drop_nxt = key_valid;
            if (wr_addr == LAST_ADDR) begin
               state_nxt  = IDLE;
               busy_nxt   = 1'b0;
               done_nxt   = 1'b1;
               col_nxt    = '0;
               row_nxt    = '0;
               ignore_nxt = 1'b0;
            end else begin
               wr_en_nxt = 1'b1;
               addr_nxt  = wr_addr + AW'(1);
               data_nxt  = K_BLANK;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         cur_col    <= '0;
         cur_row    <= '0;
         ignore_q   <= 1'b0;
         pend_q     <= 1'b0;
         pcode_q    <= '0;
         wr_en      <= 1'b0;
         wr_addr    <= '0;
         wr_data    <= '0;
         busy       <= 1'b0;
         clear_done <= 1'b0;
         key_drop   <= 1'b0;
      end else begin
         state      <= state_nxt;
         cur_col    <= col_nxt;
         cur_row    <= row_nxt;
         ignore_q   <= ignore_nxt;
         pend_q     <= pend_nxt;
         pcode_q    <= pcode_nxt;
         wr_en      <= wr_en_nxt;
         wr_addr    <= addr_nxt;
         wr_data    <= data_nxt;
         busy       <= busy_nxt;
         clear_done <= done_nxt;
         key_drop   <= drop_nxt;
      end
   end

endmodule

// File: tb/tb_text_cursor_writer.sv
// Directed bench for text_cursor_writer at 40x15, WRAP_MODE 0 and 1 side by side.
module tb_text_cursor_writer;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       key_valid = 1'b0;
   logic [9:0] key_code = '0;
   logic       clear_req = 1'b0;

   logic       wr_en, busy, clear_done, key_drop;
   logic [9:0] wr_addr, wr_data;
   logic [5:0] cur_col;
   logic [3:0] cur_row;
   logic       wr_en1, busy1, clear_done1, key_drop1;
   logic [9:0] wr_addr1, wr_data1;
   logic [5:0] cur_col1;
   logic [3:0] cur_row1;

   int n_checks = 0;
   int n_fail   = 0;
   int wcnt0 = 0, wcnt1 = 0;
   logic [9:0] laddr0 = '0, ldata0 = '0, laddr1 = '0;

   text_cursor_writer #(.WRAP_MODE(0)) dut (
      .clk(clk), .rst_n(rst_n), .key_valid(key_valid), .key_code(key_code),
      .clear_req(clear_req), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .cur_col(cur_col), .cur_row(cur_row), .busy(busy), .clear_done(clear_done),
      .key_drop(key_drop));

   text_cursor_writer #(.WRAP_MODE(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .key_valid(key_valid), .key_code(key_code),
      .clear_req(clear_req), .wr_en(wr_en1), .wr_addr(wr_addr1), .wr_data(wr_data1),
      .cur_col(cur_col1), .cur_row(cur_row1), .busy(busy1), .clear_done(clear_done1),
      .key_drop(key_drop1));

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (wr_en) begin
         wcnt0++;
         laddr0 = wr_addr;
         ldata0 = wr_data;
      end
      if (wr_en1) begin
         wcnt1++;
         laddr1 = wr_addr1;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic key(input logic [9:0] code);
      key_valid = 1'b1;
      key_code  = code;
      @(posedge clk); #1;
      key_valid = 1'b0;
   endtask

   task automatic drain();
      @(posedge clk);
      @(negedge clk); #1;
   endtask

   task automatic do_reset();
      key_valid = 1'b0;
      clear_req = 1'b0;
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      key_valid = 1'b1;
      key_code = 10'h05;
      repeat (3) @(posedge clk);
      #1;
      key_valid = 1'b0;
      n_checks++; if (wr_en !== 1'b0) begin n_fail++; $display("FAIL reset wr_en: got %0d want 0", wr_en); end
      n_checks++; if (busy !== 1'b0 || clear_done !== 1'b0 || key_drop !== 1'b0) begin n_fail++; $display("FAIL reset flags: got busy %0d done %0d drop %0d want 0", busy, clear_done, key_drop); end
      n_checks++; if (cur_col !== 6'd0 || cur_row !== 4'd0) begin n_fail++; $display("FAIL reset cursor: got (%0d,%0d) want (0,0)", cur_col, cur_row); end
      n_checks++; if (wr_addr !== 10'd0 || wr_data !== 10'd0) begin n_fail++; $display("FAIL reset addr/data: got %0d/%0d want 0/0", wr_addr, wr_data); end
      @(posedge clk); #1;
      rst_n = 1'b1;
   endtask

   task automatic test_two_keys();
      int w0;
      do_reset();
      w0 = wcnt0;
      key(10'h05);
      key(10'h06);
      n_checks++; if (wr_en !== 1'b1 || wr_addr !== 10'd0 || wr_data !== 10'h05) begin n_fail++; $display("FAIL two_keys first: got en %0d addr %0d data %0h want 1/0/05", wr_en, wr_addr, wr_data); end
      drain();
      n_checks++; if (wr_addr !== 10'd1 || wr_data !== 10'h06) begin n_fail++; $display("FAIL two_keys second: got addr %0d data %0h want 1/06", wr_addr, wr_data); end
      n_checks++; if (wcnt0 - w0 !== 2) begin n_fail++; $display("FAIL two_keys count: got %0d want 2", wcnt0 - w0); end
      n_checks++; if (cur_col !== 6'd2 || cur_row !== 4'd0) begin n_fail++; $display("FAIL two_keys cursor: got (%0d,%0d) want (2,0)", cur_col, cur_row); end
      @(posedge clk); #1;
      n_checks++; if (wr_en !== 1'b0 || wr_addr !== 10'd1) begin n_fail++; $display("FAIL two_keys hold: got en %0d addr %0d want 0/1", wr_en, wr_addr); end
   endtask

   task automatic test_row_advance();
      int w0;
      do_reset();
      w0 = wcnt0;
      for (int i = 0; i < 41; i++) key(10'h10 + 10'(i));
      drain();
      n_checks++; if (wcnt0 - w0 !== 41) begin n_fail++; $display("FAIL row_adv count: got %0d want 41", wcnt0 - w0); end
      n_checks++; if (laddr0 !== 10'd40 || ldata0 !== 10'h38) begin n_fail++; $display("FAIL row_adv last: got addr %0d data %0h want 40/38", laddr0, ldata0); end
      n_checks++; if (cur_col !== 6'd1 || cur_row !== 4'd1) begin n_fail++; $display("FAIL row_adv cursor: got (%0d,%0d) want (1,1)", cur_col, cur_row); end
   endtask

   task automatic test_break();
      int w0;
      do_reset();
      w0 = wcnt0;
      key(10'h0F0);
      key(10'h05);
      key(10'h07);
      drain();
      n_checks++; if (wcnt0 - w0 !== 1) begin n_fail++; $display("FAIL break count: got %0d want 1", wcnt0 - w0); end
      n_checks++; if (laddr0 !== 10'd0 || ldata0 !== 10'h07) begin n_fail++; $display("FAIL break write: got addr %0d data %0h want 0/07", laddr0, ldata0); end
      n_checks++; if (cur_col !== 6'd1 || cur_row !== 4'd0) begin n_fail++; $display("FAIL break cursor: got (%0d,%0d) want (1,0)", cur_col, cur_row); end
   endtask

   task automatic test_printable_edge();
      int w0;
      do_reset();
      w0 = wcnt0;
      key(10'd73);
      key(10'd74);
      key(10'h100);
      drain();
      n_checks++; if (wcnt0 - w0 !== 1 || ldata0 !== 10'd73) begin n_fail++; $display("FAIL print_edge: got %0d writes last data %0d want 1/73", wcnt0 - w0, ldata0); end
      n_checks++; if (cur_col !== 6'd1 || cur_row !== 4'd0) begin n_fail++; $display("FAIL print_edge cursor: got (%0d,%0d) want (1,0)", cur_col, cur_row); end
   endtask

   task automatic test_enter();
      int w0, w1;
      do_reset();
      key(10'h05);
      drain();
      w0 = wcnt0;
      w1 = wcnt1;
      for (int i = 0; i < 14; i++) key(10'h0C0);
      drain();
      n_checks++; if (cur_col !== 6'd0 || cur_row !== 4'd14) begin n_fail++; $display("FAIL enter rows: got (%0d,%0d) want (0,14)", cur_col, cur_row); end
      key(10'h0C0);
      drain();
      n_checks++; if (cur_col !== 6'd0 || cur_row !== 4'd0) begin n_fail++; $display("FAIL enter wrap0: got (%0d,%0d) want (0,0)", cur_col, cur_row); end
      n_checks++; if (cur_col1 !== 6'd0 || cur_row1 !== 4'd14) begin n_fail++; $display("FAIL enter wrap1: got (%0d,%0d) want (0,14)", cur_col1, cur_row1); end
      n_checks++; if (wcnt0 - w0 !== 0 || wcnt1 - w1 !== 0) begin n_fail++; $display("FAIL enter writes: got %0d/%0d want 0/0", wcnt0 - w0, wcnt1 - w1); end
   endtask

   task automatic test_backspace();
      do_reset();
      key(10'h0C0);
      key(10'h108);
      drain();
      n_checks++; if (wr_en !== 1'b1 || wr_addr !== 10'd39 || wr_data !== 10'd0) begin n_fail++; $display("FAIL bksp row: got en %0d addr %0d data %0d want 1/39/0", wr_en, wr_addr, wr_data); end
      n_checks++; if (cur_col !== 6'd39 || cur_row !== 4'd0) begin n_fail++; $display("FAIL bksp row cursor: got (%0d,%0d) want (39,0)", cur_col, cur_row); end
      do_reset();
      key(10'h108);
      drain();
      n_checks++; if (wr_en !== 1'b1 || wr_addr !== 10'd599) begin n_fail++; $display("FAIL bksp home wrap0: got en %0d addr %0d want 1/599", wr_en, wr_addr); end
      n_checks++; if (cur_col !== 6'd39 || cur_row !== 4'd14) begin n_fail++; $display("FAIL bksp home cursor0: got (%0d,%0d) want (39,14)", cur_col, cur_row); end
      n_checks++; if (wr_en1 !== 1'b1 || wr_addr1 !== 10'd0 || cur_col1 !== 6'd0 || cur_row1 !== 4'd0) begin n_fail++; $display("FAIL bksp home wrap1: got en %0d addr %0d (%0d,%0d) want 1/0 (0,0)", wr_en1, wr_addr1, cur_col1, cur_row1); end
   endtask

   task automatic test_clear();
      int busy_cycles, bad;
      do_reset();
      key(10'h05);
      key(10'h0F0);
      @(posedge clk); #1;
      clear_req = 1'b1;
      key_valid = 1'b1;
      key_code  = 10'h09;
      @(posedge clk); #1;
      clear_req = 1'b0;
      key_valid = 1'b0;
      n_checks++; if (key_drop !== 1'b1 || busy !== 1'b1) begin n_fail++; $display("FAIL clear start: got drop %0d busy %0d want 1/1", key_drop, busy); end
      busy_cycles = 0;
      bad = 0;
      for (int i = 0; i < 700 && busy === 1'b1; i++) begin
         if (wr_en !== 1'b1 || wr_addr !== 10'(i) || wr_data !== 10'd0) begin
            if (bad == 0) $display("FAIL clear sweep at %0d: got en %0d addr %0d data %0d", i, wr_en, wr_addr, wr_data);
            bad++;
         end
         if (i == 100) begin key_valid = 1'b1; key_code = 10'h05; end
         if (i == 101) begin
            key_valid = 1'b0;
            n_checks++; if (key_drop !== 1'b1) begin n_fail++; $display("FAIL clear key_drop: got %0d want 1", key_drop); end
         end
         if (i == 200) clear_req = 1'b1;
         if (i == 201) clear_req = 1'b0;
         busy_cycles++;
         @(posedge clk); #1;
      end
      n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL clear sweep errors: got %0d want 0", bad); end
      n_checks++; if (busy_cycles !== 600) begin n_fail++; $display("FAIL clear busy cycles: got %0d want 600", busy_cycles); end
      n_checks++; if (clear_done !== 1'b1 || wr_en !== 1'b0) begin n_fail++; $display("FAIL clear done: got done %0d en %0d want 1/0", clear_done, wr_en); end
      n_checks++; if (cur_col !== 6'd0 || cur_row !== 4'd0) begin n_fail++; $display("FAIL clear cursor: got (%0d,%0d) want (0,0)", cur_col, cur_row); end
      @(posedge clk); #1;
      n_checks++; if (clear_done !== 1'b0) begin n_fail++; $display("FAIL clear done pulse: got %0d want 0", clear_done); end
      key(10'h07);
      @(posedge clk); #1;
      n_checks++; if (wr_en !== 1'b1 || wr_addr !== 10'd0 || wr_data !== 10'h07) begin n_fail++; $display("FAIL clear ignore reset: got en %0d addr %0d data %0h want 1/0/07", wr_en, wr_addr, wr_data); end
   endtask

   task automatic test_reset_mid_clear();
      int w0;
      do_reset();
      clear_req = 1'b1;
      @(posedge clk); #1;
      clear_req = 1'b0;
      for (int k = 0; k < 400 && wr_addr !== 10'd300; k++) begin
         @(posedge clk); #1;
      end
      n_checks++; if (wr_addr !== 10'd300 || wr_en !== 1'b1) begin n_fail++; $display("FAIL mid_clear reach: got addr %0d en %0d want 300/1", wr_addr, wr_en); end
      rst_n = 1'b0;
      #1;
      n_checks++; if (wr_en !== 1'b0 || busy !== 1'b0 || wr_addr !== 10'd0) begin n_fail++; $display("FAIL mid_clear abort: got en %0d busy %0d addr %0d want 0/0/0", wr_en, busy, wr_addr); end
      @(posedge clk); #1;
      rst_n = 1'b1;
      w0 = wcnt0;
      repeat (20) @(posedge clk);
      @(negedge clk); #1;
      n_checks++; if (wcnt0 - w0 !== 0 || busy !== 1'b0) begin n_fail++; $display("FAIL mid_clear quiet: got %0d writes busy %0d want 0/0", wcnt0 - w0, busy); end
   endtask

   initial begin
      test_reset();
      test_two_keys();
      test_row_advance();
      test_break();
      test_printable_edge();
      test_enter();
      test_backspace();
      test_clear();
      test_reset_mid_clear();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/text_cursor_writer.md
TEXT_CURSOR_WRITER -- requirements
Module: text_cursor_writer

Interface
REQ-001 SHALL have parameter COLS, default 40, meaning characters per row.
REQ-002 SHALL have parameter ROWS, default 15, meaning rows on screen.
REQ-003 SHALL have parameter CODE_W, default 10, meaning key code and character width.
REQ-004 SHALL have parameter PRINT_MAX, default 74; codes below this value are printable.
REQ-005 SHALL have parameters BREAK_CODE 'h0F0, ENTER_CODE 'h0C0, BKSP_CODE 'h108 and BLANK 0.
REQ-006 SHALL have parameter WRAP_MODE, default 0: 0 wraps the cursor to the top row, 1 holds it on the last row.
REQ-007 SHALL derive AW = $clog2(COLS*ROWS), used as the address width.
REQ-008 clk  in  1  single clock, all state changes on its rising edge.
REQ-009 rst_n  in  1  asynchronous, active-low reset.
REQ-010 key_valid  in  1  one-cycle strobe qualifying key_code.
REQ-011 key_code  in  CODE_W  decoded keyboard code.
REQ-012 clear_req  in  1  request to blank the whole screen.
REQ-013 wr_en  out  1  memory write strobe.
REQ-014 wr_addr  out  AW  write address, row*COLS+col, zero-based.
REQ-015 wr_data  out  CODE_W  write data.
REQ-016 cur_col  out  $clog2(COLS)  cursor column.
REQ-017 cur_row  out  $clog2(ROWS)  cursor row.
REQ-018 busy  out  1  high while a clear is running.
REQ-019 clear_done  out  1  one-cycle pulse when a clear finishes.
REQ-020 key_drop  out  1  one-cycle pulse when a key_valid is discarded.

Function
REQ-021 SHALL register all outputs; wr_en is a single-cycle pulse, and wr_addr/wr_data hold their last value when wr_en is 0.
REQ-022 SHALL implement the states IDLE and CLEAR.
REQ-023 In IDLE, a key_valid at edge N SHALL produce its write and cursor update, visible after edge N+1.
REQ-024 When key_code == BREAK_CODE, the block SHALL set the ignore flag and perform no write.
REQ-025 When the ignore flag is set, the next key_valid SHALL be consumed with no write and no cursor move, and the flag SHALL clear.
REQ-026 A printable key SHALL write key_code at the current cursor, then advance the cursor.
REQ-027 Advance rule: col+1; at col COLS-1 the cursor goes to col 0 of the next row.
REQ-028 Next-row rule: at row ROWS-1, WRAP_MODE 0 goes to row 0 and WRAP_MODE 1 stays on row ROWS-1.
REQ-029 ENTER_CODE SHALL set col to 0 and apply the next-row rule, with no write.
REQ-030 BKSP_CODE SHALL retreat the cursor one cell, then write BLANK at the new position in the same update.
REQ-031 Retreat rule: col-1; at col 0 the cursor goes to COLS-1 of the previous row.
REQ-032 Retreat from (0,0): WRAP_MODE 0 goes to (COLS-1,ROWS-1), and WRAP_MODE 1 stays at (0,0) while still writing BLANK at address 0.
REQ-033 Any other non-printable code SHALL be ignored, with no write and no cursor change.
REQ-034 clear_req in IDLE SHALL enter CLEAR, and busy SHALL rise at the next edge.
REQ-035 CLEAR SHALL write BLANK to addresses 0..COLS*ROWS-1 in order, one per cycle, with no gaps.
REQ-036 After the last address, CLEAR SHALL set the cursor to (0,0), clear the ignore flag, drop busy, pulse clear_done and return to IDLE.
REQ-037 A key_valid during CLEAR, or in the same cycle as an accepted clear_req, SHALL be discarded and pulse key_drop.
REQ-038 clear_req during CLEAR SHALL be ignored.
REQ-039 Address arithmetic SHALL never produce a value at or above COLS*ROWS.

Reset
REQ-040 While rst_n is low, the block SHALL be in IDLE with the cursor at (0,0), the ignore flag clear, and wr_en, busy, clear_done and key_drop at 0.
REQ-041 While rst_n is low, wr_addr and wr_data SHALL be 0.
REQ-042 Reset asserted mid-CLEAR SHALL abort the sweep immediately, with no further writes after rst_n rises until new stimulus arrives.

Verification (COLS=40, ROWS=15)
REQ-043 Keys 'h05, 'h06 from reset -> writes addr 0 data 'h05, then addr 1 data 'h06; cursor (2,0).
REQ-044 41 printable keys from (0,0) -> the 41st writes addr 40; cursor (1,1).
REQ-045 Sequence 'h0F0, 'h05, 'h07 -> exactly one write, addr 0 data 'h07.
REQ-046 Cursor at (0,14), ENTER -> WRAP_MODE 0 gives (0,0); WRAP_MODE 1 gives (0,14); no wr_en in either case.
REQ-047 BKSP at (0,1) -> write BLANK at addr 39; cursor (39,0). BKSP at (0,0) with WRAP_MODE 0 -> write at addr 599; cursor (39,14).
REQ-048 clear_req plus key_valid in the same cycle -> key_drop pulses and 600 consecutive BLANK writes at addrs 0..599 follow; busy is high for 600 cycles, then clear_done pulses with cursor (0,0). With rst_n pulsed low at write 300 -> no further writes.
